// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_ctrl
// Brief   : Control FSM for the multi-cycle CPU. It sequences the datapath
//           write enables and mux selects, handshakes with memory, and latches
//           an error on illegal opcodes or memory hangs.
// Revision: 1.0  initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       mdr_we,
    output logic       ab_we,
    output logic       alu_out_we,
    output logic       rf_we,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       iord,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IF  = 4'd0,
        S_ID  = 4'd1,
        S_MA  = 4'd2,
        S_MR  = 4'd3,
        S_WBM = 4'd4,
        S_MW  = 4'd5,
        S_EXR = 4'd6,
        S_WBR = 4'd7,
        S_BR  = 4'd8,
        S_JMP = 4'd9,
        S_EXI = 4'd10,
        S_WBI = 4'd11,
        S_ERR = 4'd15
    } state_t;

    localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CW-1:0] c_CNT_LAST = CW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_wait_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          w_waiting;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IF;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_cnt_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_waiting  = 1'b0;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        mdr_we     = 1'b0;
        ab_we      = 1'b0;
        alu_out_we = 1'b0;
        rf_we      = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        iord       = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        err        = 1'b0;

        case (r_state)
            S_IF: begin
                w_waiting = 1'b1;
                mem_rd    = 1'b1;
                alu_src_b = 2'b01;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
                if (mem_ready) w_next = S_ID;
            end
            S_ID: begin
                // ALU computes the branch target speculatively while decoding
                ab_we      = 1'b1;
                alu_out_we = 1'b1;
                alu_src_b  = 2'b11;
                case (opcode)
                    c_OP_RTYPE:       w_next = S_EXR;
                    c_OP_LW, c_OP_SW: w_next = S_MA;
                    c_OP_BEQ:         w_next = S_BR;
                    c_OP_J:           w_next = S_JMP;
                    c_OP_ADDI:        w_next = S_EXI;
                    default:          w_next = S_ERR;
                endcase
            end
            S_MA: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_out_we = 1'b1;
                w_next     = (opcode == c_OP_LW) ? S_MR : S_MW;
            end
            S_MR: begin
                w_waiting = 1'b1;
                mem_rd    = 1'b1;
                iord      = 1'b1;
                mdr_we    = mem_ready;
                if (mem_ready) w_next = S_WBM;
            end
            S_WBM: begin
                rf_we      = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                w_next     = S_IF;
            end
            S_MW: begin
                w_waiting  = 1'b1;
                mem_wr     = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) w_next = S_IF;
            end
            S_EXR: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                alu_out_we = 1'b1;
                w_next     = S_WBR;
            end
            S_WBR: begin
                rf_we      = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                w_next     = S_IF;
            end
            S_BR: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                pc_we      = zero;
                instr_done = 1'b1;
                w_next     = S_IF;
            end
            S_JMP: begin
                pc_src     = 2'b10;
                pc_we      = 1'b1;
                instr_done = 1'b1;
                w_next     = S_IF;
            end
            S_EXI: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_out_we = 1'b1;
                w_next     = S_WBI;
            end
            S_WBI: begin
                rf_we      = 1'b1;
                instr_done = 1'b1;
                w_next     = S_IF;
            end
            S_ERR: begin
                err    = 1'b1;
                w_next = S_ERR;
            end
            default: w_next = S_ERR;
        endcase

        // mem_ready in the limit cycle still advances normally
        if (WAIT_LIMIT != 0 && w_waiting && !mem_ready && r_wait_cnt == c_CNT_LAST)
            w_next = S_ERR;
    end

    always_comb begin
        w_cnt_next = r_wait_cnt;
        if (w_next != r_state)
            w_cnt_next = '0;
        else if (w_waiting && !mem_ready)
            w_cnt_next = r_wait_cnt + CW'(1);
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// Testbench for multicycle_ctrl: directed scenarios followed by random traffic,
// all checked against a path-table reference model.
module tb_multicycle_ctrl;

    localparam int WL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic       pc_we, ir_we, mdr_we, ab_we, alu_out_we, rf_we;
    logic       mem_rd, mem_wr, iord, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       reg_dst, mem_to_reg, instr_done, err;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    int m_state = 0;
    int m_cnt   = 0;
    int m_pos   = 0;
    int path[$];

    multicycle_ctrl #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_we(pc_we), .ir_we(ir_we), .mdr_we(mdr_we), .ab_we(ab_we),
        .alu_out_we(alu_out_we), .rf_we(rf_we), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .iord(iord), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .instr_done(instr_done), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    wire [19:0] obs = {pc_we, ir_we, mdr_we, ab_we, alu_out_we, rf_we, mem_rd, mem_wr,
                       iord, alu_src_a, alu_src_b, alu_op, pc_src, reg_dst, mem_to_reg,
                       instr_done, err};

    // Expected output row for each state, written straight from the state table
    function automatic logic [19:0] expect_out(int s, logic mr, logic z);
        logic pcw = 0, irw = 0, mdrw = 0, abw = 0, aow = 0, rfw = 0, rd = 0, wr = 0;
        logic io = 0, sa = 0, rdst = 0, m2r = 0, done = 0, er = 0;
        logic [1:0] sb = 0, op = 0, ps = 0;
        case (s)
            0:  begin rd = 1; sb = 2'b01; irw = mr; pcw = mr; end
            1:  begin abw = 1; aow = 1; sb = 2'b11; end
            2:  begin sa = 1; sb = 2'b10; aow = 1; end
            3:  begin rd = 1; io = 1; mdrw = mr; end
            4:  begin rfw = 1; m2r = 1; done = 1; end
            5:  begin wr = 1; io = 1; done = mr; end
            6:  begin sa = 1; op = 2'b10; aow = 1; end
            7:  begin rfw = 1; rdst = 1; done = 1; end
            8:  begin sa = 1; op = 2'b01; ps = 2'b01; pcw = z; done = 1; end
            9:  begin ps = 2'b10; pcw = 1; done = 1; end
            10: begin sa = 1; sb = 2'b10; aow = 1; end
            11: begin rfw = 1; done = 1; end
            default: er = 1;
        endcase
        return {pcw, irw, mdrw, abw, aow, rfw, rd, wr, io, sa, sb, op, ps, rdst, m2r, done, er};
    endfunction

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic go_next();
        if (m_state == 0) begin
            m_state = 1;
            m_pos   = 1;
        end else begin
            m_pos++;
            if (m_pos >= path.size()) begin
                m_state = 0;
                m_pos   = 0;
            end else begin
                m_state = path[m_pos];
            end
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_edge();
        if (m_state == 15) return;
        if (m_state == 0 || m_state == 3 || m_state == 5) begin
            if (mem_ready) begin
                m_cnt = 0;
                go_next();
            end else if (WL != 0 && m_cnt == WL - 1) begin
                m_cnt   = 0;
                m_state = 15;
            end else begin
                m_cnt++;
            end
        end else if (m_state == 1) begin
            case (opcode)
                6'b000000: path = '{0, 1, 6, 7};
                6'b100011: path = '{0, 1, 2, 3, 4};
                6'b101011: path = '{0, 1, 2, 5};
                6'b000100: path = '{0, 1, 8};
                6'b000010: path = '{0, 1, 9};
                6'b001000: path = '{0, 1, 10, 11};
                default:   path = {};
            endcase
            if (path.size() == 0) m_state = 15;
            else begin
                m_pos   = 2;
                m_state = path[2];
            end
        end else begin
            go_next();
        end
    endtask

    task automatic step(logic mr, logic z);
        mem_ready = mr;
        zero      = z;
        #1;
        chk("outputs", 32'(obs), 32'(expect_out(m_state, mr, z)));
        chk("state", 32'(state), 32'(m_state));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'b0;
        #1;
        m_state = 0;
        m_cnt   = 0;
        m_pos   = 0;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_outputs", 32'(obs), 32'(expect_out(0, 1'b0, zero)));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // R-type with memory always ready
        do_reset();
        opcode = 6'b000000;
        repeat (3) step(1'b1, 1'b0);
        mem_ready = 1'b1;
        #1;
        chk("r_wb_rf_we", 32'({rf_we, reg_dst, state}), 32'({2'b11, 4'd7}));
        step(1'b1, 1'b0);
        chk("r_back_if", 32'(state), 32'd0);

        // lw with MR stalled three cycles
        opcode = 6'b100011;
        repeat (3) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("lw_wbm", 32'({state, mem_to_reg, instr_done}), 32'({4'd4, 2'b11}));
        step(1'b1, 1'b0);

        // beq taken and not taken
        opcode = 6'b000100;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("beq_back_if", 32'(state), 32'd0);

        // illegal opcode is absorbing
        opcode = 6'b111111;
        repeat (2) step(1'b1, 1'b0);
        repeat (20) step(1'($urandom_range(0, 1)), 1'b0);
        chk("illegal_err", 32'({err, state}), 32'({1'b1, 4'd15}));
        do_reset();
        chk("err_cleared", 32'(err), 32'd0);

        // IF timeout, then ready arriving on the limit cycle
        opcode = 6'b001000;
        repeat (WL) step(1'b0, 1'b0);
        chk("timeout_err", 32'(state), 32'd15);
        do_reset();
        repeat (WL - 1) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("limit_ready_id", 32'({err, state}), 32'({1'b0, 4'd1}));
        do_reset();

        // reset mid store drops mem_wr immediately
        opcode = 6'b101011;
        repeat (3) step(1'b1, 1'b0);
        mem_ready = 1'b0;
        #1;
        chk("mw_wr_on", 32'(mem_wr), 32'd1);
        do_reset();
        chk("rst_mw_wr_off", 32'(mem_wr), 32'd0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            if (m_state == 15) begin
                do_reset();
            end else begin
                if (m_state == 0) begin
                    case ($urandom_range(0, 6))
                        0: opcode = 6'b000000;
                        1: opcode = 6'b100011;
                        2: opcode = 6'b101011;
                        3: opcode = 6'b000100;
                        4: opcode = 6'b000010;
                        5: opcode = 6'b001000;
                        default: opcode = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b000000;
                    endcase
                end
                step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
